// File: rtl/vga_sync_timing.sv
// 640x480@60 Hz VGA raster timing: pixel-rate divider, h/v counters, registered
// sync, active-video and frame-start outputs.
module vga_sync_timing #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] pixelX,
  output logic [9:0] pixelY,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_timing: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_timing: CLK_DIV must be in 1..16");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             div_wrap, tick_d, frame_d;
  logic [9:0]       x_d, y_d, x_after, y_after;

  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    x_d      = (pixelX == H_LAST) ? 10'd0 : pixelX + 10'd1;
    y_d      = pixelY;
    if (pixelX == H_LAST) begin
      y_d = (pixelY == V_LAST) ? 10'd0 : pixelY + 10'd1;
    end
    x_after  = div_wrap ? x_d : pixelX;
    y_after  = div_wrap ? y_d : pixelY;
    // Tick/frame strobes are registered one clock ahead so they sit in the
    // clock whose closing edge performs the advance.
    tick_d   = (div_d == DIV_LAST);
    frame_d  = tick_d && (x_after == H_LAST) && (y_after == V_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      pixelX      <= 10'd0;
      pixelY      <= 10'd0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      div_q       <= div_d;
      pixel_tick  <= tick_d;
      frame_start <= frame_d;
      if (div_wrap) begin
        pixelX   <= x_d;
        pixelY   <= y_d;
        hsync    <= (x_d >= HS_START && x_d <= HS_STOP) ? HS_POL : ~HS_POL;
        vsync    <= (y_d >= VS_START && y_d <= VS_STOP) ? VS_POL : ~VS_POL;
        video_on <= (x_d < H_ACT) && (y_d < V_ACT);
      end
    end else begin
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: default 640x480 timing, CLK_DIV=1, and a shrunken
// raster with inverted polarity, all checked against an arithmetic raster model.
module tb_vga_sync_timing;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic hsa, vsa, voa, pta, fsa;
  logic hsb, vsb, vob, ptb, fsb;
  logic hsc, vsc, voc, ptc, fsc;
  logic [24:0] obs_a, obs_b, obs_c;

  int compared = 0;
  int mismatched = 0;

  // Enabled edges since reset, and whether the last edge was enabled.
  longint n_a, n_b, n_c;
  logic ev_a, ev_b, ev_c;

  always #5 clock = ~clock;

  vga_sync_timing dut_a (
    .clock(clock), .reset(reset), .enable(en_a), .pixelX(xa), .pixelY(ya),
    .hsync(hsa), .vsync(vsa), .video_on(voa), .pixel_tick(pta), .frame_start(fsa)
  );

  vga_sync_timing #(.CLK_DIV(1)) dut_b (
    .clock(clock), .reset(reset), .enable(en_b), .pixelX(xb), .pixelY(yb),
    .hsync(hsb), .vsync(vsb), .video_on(vob), .pixel_tick(ptb), .frame_start(fsb)
  );

  vga_sync_timing #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_c (
    .clock(clock), .reset(reset), .enable(en_c), .pixelX(xc), .pixelY(yc),
    .hsync(hsc), .vsync(vsc), .video_on(voc), .pixel_tick(ptc), .frame_start(fsc)
  );

  assign obs_a = {xa, ya, hsa, vsa, voa, pta, fsa};
  assign obs_b = {xb, yb, hsb, vsb, vob, ptb, fsb};
  assign obs_c = {xc, yc, hsc, vsc, voc, ptc, fsc};

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      n_a <= 0; n_b <= 0; n_c <= 0;
      ev_a <= 1'b0; ev_b <= 1'b0; ev_c <= 1'b0;
    end else begin
      if (en_a) n_a <= n_a + 1;
      if (en_b) n_b <= n_b + 1;
      if (en_c) n_c <= n_c + 1;
      ev_a <= en_a; ev_b <= en_b; ev_c <= en_c;
    end
  end

  // Raster position is simply (enabled clocks / divider) laid out row-major.
  function automatic logic [24:0] model(longint n, logic ev, int d, int ha, int hf, int hs,
                                        int hb, int va, int vf, int vs, int vb,
                                        logic hp, logic vp);
    int ht, vt, x, y;
    longint pix;
    logic tk, fs, von, h, v;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    pix = n / d;
    x   = int'(pix % ht);
    y   = int'((pix / ht) % vt);
    tk  = ev && ((n % d) == d - 1);
    fs  = tk && (x == ht - 1) && (y == vt - 1);
    von = (pix > 0) && (x < ha) && (y < va);
    h   = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
    v   = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
    return {x[9:0], y[9:0], h, v, von, tk, fs};
  endfunction

  function automatic logic [24:0] exp_a();
    return model(n_a, ev_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction
  function automatic logic [24:0] exp_b();
    return model(n_b, ev_b, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction
  function automatic logic [24:0] exp_c();
    return model(n_c, ev_c, 3, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1, 1'b1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    compared++;
    if (obs_a !== {10'd0, 10'd0, 1'b1, 1'b1, 3'b000}) begin
      mismatched++; $display("FAIL reset_a got %h want %h", obs_a, {20'd0, 5'b11000});
    end
    compared++;
    if (obs_b !== {10'd0, 10'd0, 1'b1, 1'b1, 3'b000}) begin
      mismatched++; $display("FAIL reset_b got %h want %h", obs_b, {20'd0, 5'b11000});
    end
    compared++;
    if (obs_c !== {10'd0, 10'd0, 1'b0, 1'b0, 3'b000}) begin
      mismatched++; $display("FAIL reset_c got %h want %h", obs_c, {20'd0, 5'b00000});
    end
    reset = 1'b0;
  endtask

  task automatic test_first_ticks();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      compared++;
      if (obs_a !== exp_a()) begin
        mismatched++; $display("FAIL first_a k=%0d got %h want %h", k, obs_a, exp_a());
      end
      if (k == 2) begin
        compared++;
        if (pta !== 1'b0) begin mismatched++; $display("FAIL early_tick got %b want 0", pta); end
      end
      if (k == 3) begin
        compared++;
        if (pta !== 1'b1) begin mismatched++; $display("FAIL tick4 got %b want 1", pta); end
      end
      if (k == 4) begin
        compared++;
        if ({xa, voa} !== {10'd1, 1'b1}) begin
          mismatched++; $display("FAIL first_pixel got x=%0d von=%b want x=1 von=1", xa, voa);
        end
      end
    end
  endtask

  task automatic test_line();
    int hs_low;
    logic [9:0] y0;
    hs_low = 0;
    y0 = ya;
    for (int i = 0; i < 3200; i++) begin
      @(negedge clock);
      if (hsa == 1'b0) hs_low++;
      compared++;
      if (obs_a !== exp_a()) begin
        mismatched++; $display("FAIL line_a got %h want %h", obs_a, exp_a());
      end
      compared++;
      if (obs_b !== exp_b()) begin
        mismatched++; $display("FAIL line_b got %h want %h", obs_b, exp_b());
      end
      compared++;
      if (obs_c !== exp_c()) begin
        mismatched++; $display("FAIL line_c got %h want %h", obs_c, exp_c());
      end
    end
    compared++;
    if (hs_low != 384) begin
      mismatched++; $display("FAIL hsync_width got %0d clocks want 384", hs_low);
    end
    compared++;
    if (ya !== y0 + 10'd1) begin
      mismatched++; $display("FAIL line_y got %0d want %0d", ya, y0 + 10'd1);
    end
  endtask

  task automatic test_enable_hold();
    logic [24:0] held;
    int guard;
    guard = 0;
    while (xa !== 10'd100 && guard < 4000) begin
      @(negedge clock);
      guard++;
    end
    compared++;
    if (xa !== 10'd100) begin
      mismatched++; $display("FAIL reach_x100 got %0d want 100", xa);
    end
    held = obs_a;
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      compared++;
      if (obs_a !== held) begin
        mismatched++; $display("FAIL hold got %h want %h", obs_a, held);
      end
      compared++;
      if (obs_a !== exp_a()) begin
        mismatched++; $display("FAIL hold_model got %h want %h", obs_a, exp_a());
      end
    end
    en_a = 1'b1;
    guard = 0;
    while (pta !== 1'b1 && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    compared++;
    if (guard != 3) begin
      mismatched++; $display("FAIL resume_phase got %0d clocks want 3", guard);
    end
    @(negedge clock);
    compared++;
    if (xa !== 10'd101) begin
      mismatched++; $display("FAIL resume_x got %0d want 101", xa);
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      compared++;
      if (obs_a !== exp_a()) begin
        mismatched++; $display("FAIL rand_a got %h want %h", obs_a, exp_a());
      end
      compared++;
      if (obs_b !== exp_b()) begin
        mismatched++; $display("FAIL rand_b got %h want %h", obs_b, exp_b());
      end
      compared++;
      if (obs_c !== exp_c()) begin
        mismatched++; $display("FAIL rand_c got %h want %h", obs_c, exp_c());
      end
      en_a = ($urandom_range(0, 3) != 0);
      en_b = ($urandom_range(0, 3) != 0);
      en_c = ($urandom_range(0, 3) != 0);
    end
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
  endtask

  task automatic test_frame_c();
    int guard, ticks, vid, vs_ticks, frames;
    guard = 0; ticks = 0; vid = 0; vs_ticks = 0; frames = 0;
    while (fsc !== 1'b1 && guard < 600) begin
      @(negedge clock);
      guard++;
    end
    compared++;
    if (fsc !== 1'b1) begin
      mismatched++; $display("FAIL frame_wait got %b want 1", fsc);
    end
    for (int i = 0; i < 450; i++) begin
      @(negedge clock);
      if (ptc) begin
        ticks++;
        if (voc) vid++;
        if (vsc) vs_ticks++;
      end
      if (fsc) frames++;
      compared++;
      if (obs_c !== exp_c()) begin
        mismatched++; $display("FAIL frame_c got %h want %h", obs_c, exp_c());
      end
    end
    compared++;
    if (ticks != 150) begin mismatched++; $display("FAIL frame_ticks got %0d want 150", ticks); end
    compared++;
    if (vid != 48) begin mismatched++; $display("FAIL video_ticks got %0d want 48", vid); end
    compared++;
    if (vs_ticks != 30) begin
      mismatched++; $display("FAIL vsync_ticks got %0d want 30", vs_ticks);
    end
    compared++;
    if (frames != 1) begin mismatched++; $display("FAIL frame_pulses got %0d want 1", frames); end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (xa !== 10'd700 && guard < 4000) begin
      @(negedge clock);
      guard++;
    end
    compared++;
    if ({xa, hsa} !== {10'd700, 1'b0}) begin
      mismatched++; $display("FAIL pre_reset got x=%0d hs=%b want x=700 hs=0", xa, hsa);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (obs_a !== {10'd0, 10'd0, 1'b1, 1'b1, 3'b000}) begin
      mismatched++; $display("FAIL async_reset_a got %h want %h", obs_a, {20'd0, 5'b11000});
    end
    @(negedge clock);
    reset = 1'b0;
    guard = 0;
    while (vsc !== 1'b1 && guard < 600) begin
      @(negedge clock);
      guard++;
    end
    compared++;
    if (vsc !== 1'b1) begin mismatched++; $display("FAIL vsync_wait got %b want 1", vsc); end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (obs_c !== {10'd0, 10'd0, 1'b0, 1'b0, 3'b000}) begin
      mismatched++; $display("FAIL async_reset_c got %h want %h", obs_c, {20'd0, 5'b00000});
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      compared++;
      if (obs_a !== exp_a()) begin
        mismatched++; $display("FAIL restart_a got %h want %h", obs_a, exp_a());
      end
      compared++;
      if (obs_c !== exp_c()) begin
        mismatched++; $display("FAIL restart_c got %h want %h", obs_c, exp_c());
      end
    end
  endtask

  task automatic test_clk_div1();
    int guard;
    guard = 0;
    while (xb !== 10'd0 && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    compared++;
    if (xb !== 10'd0) begin mismatched++; $display("FAIL div1_wait got %0d want 0", xb); end
    for (int i = 1; i <= 800; i++) begin
      @(negedge clock);
      compared++;
      if ({ptb, xb} !== {1'b1, 10'(i % 800)}) begin
        mismatched++;
        $display("FAIL div1_step i=%0d got tick=%b x=%0d want tick=1 x=%0d", i, ptb, xb, i % 800);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_line();
    test_enable_hold();
    test_random_enable();
    test_frame_c();
    test_reset_mid();
    test_clk_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_sync_timing.md
Name: vga_sync_timing

Overview:
- Generates 640x480@60 Hz VGA raster timing: horizontal and vertical pixel counters, sync pulses, active-video flag and frame-start strobe.
- Sits directly upstream of the VGA image generator: its pixelX/pixelY feed the generator's coordinate inputs.
- hsync/vsync drive the connector pins.
- Derives the pixel rate from the system clock with an integer divider.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- HS_POL, 0, hsync active level.
- VS_POL, 0, vsync active level.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, freezes the divider, counters and all outputs.
- pixelX  out  10  horizontal count, 0..H_TOTAL-1 (H_TOTAL=800).
- pixelY  out  10  vertical count, 0..V_TOTAL-1 (V_TOTAL=525).
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- video_on  out  1  high when pixelX<H_ACTIVE and pixelY<V_ACTIVE, registered.
- pixel_tick  out  1  one-clock pulse marking each pixel advance.
- frame_start  out  1  one-clock pulse, coincident with the pixel_tick that wraps counters to (0,0).

Behaviour:
- Reset (async, immediate) sets the following values:
  - div counter = 0, pixelX = 0, pixelY = 0.
  - pixel_tick = 0, frame_start = 0, video_on = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
- Divider:
  - div counts 0..CLK_DIV-1 while enable=1.
  - pixel_tick=1 for exactly the clock in which div==CLK_DIV-1; div then wraps to 0.
  - If CLK_DIV=1, pixel_tick is high every enabled clock.
- Horizontal counter, on a tick:
  - pixelX increments.
  - At H_TOTAL-1 it wraps to 0 and a line-end event occurs.
- Vertical counter, on line-end only:
  - pixelY increments.
  - At V_TOTAL-1 it wraps to 0.
- Simultaneous wrap: when pixelX=799 and pixelY=524 at a tick, both counters become 0 on the same edge.
  - frame_start is asserted in that cycle, aligned with the clock where pixel_tick is high.
- hsync, vsync and video_on are registered from the next counter values on each tick, so they are always aligned with the pixelX/pixelY currently on the outputs (zero skew).
- hsync = HS_POL when pixelX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], else ~HS_POL.
- vsync = VS_POL when pixelY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], else ~VS_POL.
- First pixel after reset: (0,0) is presented with video_on=0 until the first tick. This blanking of that one pixel is deliberate.
  - From the first tick on, all outputs follow the formulas above.
- enable low:
  - div, counters, hsync, vsync and video_on hold their values.
  - pixel_tick and frame_start are forced to 0.
  - Resuming continues from the held div value; no phase reset.
- Reset mid-frame: outputs go immediately to reset values, and counting restarts from (0,0).
- Latency: pixelX and the sync outputs change on the same edge. Downstream stages see registered outputs only; no combinational path from inputs to outputs.
- Arithmetic:
  - Counter widths are fixed at 10 bits.
  - Parameter sums H_TOTAL and V_TOTAL must be <=1024; elaboration-time check.

Test Plan:
- Reset released, enable=1, CLK_DIV=4: pixel_tick on clocks 4, 8, 12...; after the 1st tick, pixelX=1 and video_on=1.
- Run one line (3200 clocks):
  - hsync low exactly while pixelX in 656..751 (96 ticks = 384 clocks).
  - pixelY increments when pixelX wraps 799->0.
- Run a full frame (1,680,000 clocks):
  - vsync low only for pixelY 490..491.
  - frame_start pulses exactly once, at the 799/524 -> 0/0 wrap.
  - video_on high for exactly 307,200 ticks.
- Drop enable for 10 clocks mid-line at pixelX=100:
  - counters and div hold; no pixel_tick.
  - After re-enable, the next tick gives pixelX=101.
- Assert reset at pixelX=700, pixelY=300 (inside hsync):
  - hsync=1, vsync=1, video_on=0 and counters=0 immediately, before the next clock edge.
- CLK_DIV=1: pixel_tick constant high; pixelX increments every clock; line period 800 clocks.
